// File: rtl/env_row_decay.sv
// One row of the environment: PIXELS_X cells of {signal, sugar} with two
// registered read ports, moded single-port writes, a sequential pheromone
// evaporation sweep and a live count of cells holding sugar.
module env_row_decay #(
  parameter int PIXELS_X    = 640,
  parameter int X_bits      = 10,
  parameter int SIGNAL_bits = 4,
  parameter int DECAY_STEP  = 1,
  parameter int CNT_bits    = $clog2(PIXELS_X + 1)
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM_n,
  input  logic                   clear_row,
  input  logic                   write_en,
  input  logic [X_bits-1:0]      write_X,
  input  logic [1:0]             write_mode,
  input  logic [SIGNAL_bits-1:0] write_signal,
  input  logic                   write_sugar,
  input  logic                   decay_tick,
  input  logic [X_bits-1:0]      lookup_X,
  output logic [SIGNAL_bits:0]   lookup_data,
  input  logic [X_bits-1:0]      render_X,
  output logic [SIGNAL_bits:0]   render_data,
  output logic                   sweep_busy,
  output logic [CNT_bits-1:0]    sugar_count
);

  // Cell index width; column ports may be wider so out-of-range columns exist.
  localparam int IDX_W = (PIXELS_X > 1) ? $clog2(PIXELS_X) : 1;
  localparam logic [X_bits:0]        LP_PIX  = (X_bits + 1)'(PIXELS_X);
  localparam logic [IDX_W-1:0]       LP_LAST = IDX_W'(PIXELS_X - 1);
  localparam logic [SIGNAL_bits-1:0] LP_STEP = SIGNAL_bits'(DECAY_STEP);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_pending;
  logic [SIGNAL_bits-1:0] r_signal [PIXELS_X];
  logic                   r_sugar  [PIXELS_X];

  logic                   w_sweeping;
  logic                   w_wr_hit;
  logic                   w_lk_hit;
  logic                   w_rd_hit;
  logic [IDX_W-1:0]       w_wr_idx;
  logic [IDX_W-1:0]       w_lk_idx;
  logic [IDX_W-1:0]       w_rd_idx;
  logic [SIGNAL_bits-1:0] w_ptr_decayed;
  logic [SIGNAL_bits-1:0] w_wr_base_sig;
  logic [SIGNAL_bits:0]   w_wr_sum;
  logic                   w_wr_old_sug;
  logic [SIGNAL_bits-1:0] w_wr_new_sig;
  logic                   w_wr_new_sug;

  function automatic logic [SIGNAL_bits-1:0] f_decay(input logic [SIGNAL_bits-1:0] s);
    return (s > LP_STEP) ? (s - LP_STEP) : '0;
  endfunction

  assign w_sweeping    = (r_state == ST_SWEEP);
  assign w_wr_idx      = write_X[IDX_W-1:0];
  assign w_lk_idx      = lookup_X[IDX_W-1:0];
  assign w_rd_idx      = render_X[IDX_W-1:0];
  assign w_wr_hit      = write_en && ({1'b0, write_X} < LP_PIX);
  assign w_lk_hit      = ({1'b0, lookup_X} < LP_PIX);
  assign w_rd_hit      = ({1'b0, render_X} < LP_PIX);
  assign w_ptr_decayed = f_decay(r_signal[r_ptr]);
  assign w_wr_old_sug  = w_wr_hit ? r_sugar[w_wr_idx] : 1'b0;
  // A write landing on the cell being swept sees the already-decayed signal.
  assign w_wr_base_sig = !w_wr_hit ? '0 :
                         (w_sweeping && (r_ptr == w_wr_idx)) ? w_ptr_decayed :
                         r_signal[w_wr_idx];
  assign w_wr_sum      = {1'b0, w_wr_base_sig} + {1'b0, write_signal};

  // Next value of the written cell for each write mode.
  always_comb begin
    w_wr_new_sig = w_wr_base_sig;
    w_wr_new_sug = w_wr_old_sug;
    case (write_mode)
      2'b00: begin
        w_wr_new_sig = write_signal;
        w_wr_new_sug = write_sugar;
      end
      2'b01: w_wr_new_sig = w_wr_sum[SIGNAL_bits] ? '1 : w_wr_sum[SIGNAL_bits-1:0];
      2'b10: w_wr_new_sug = 1'b1;
      default: w_wr_new_sug = 1'b0;
    endcase
  end

  // Sweep sequencer: walks ptr over the row once per requested evaporation.
  always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_pending <= 1'b0;
    end else if (clear_row) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ptr <= '0;
          if (decay_tick) r_state <= ST_SWEEP;
        end
        ST_SWEEP: begin
          if (r_ptr == LP_LAST) begin
            r_ptr     <= '0;
            r_pending <= 1'b0;
            // A tick on the last cycle counts as pending for the next sweep.
            if (!(r_pending || decay_tick)) r_state <= ST_IDLE;
          end else begin
            r_ptr <= r_ptr + 1'b1;
            if (decay_tick) r_pending <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sweep_busy = w_sweeping;

  // Cell storage: decay of the swept cell, then the write (later assignment wins).
  always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      for (int i = 0; i < PIXELS_X; i++) begin
        r_signal[i] <= '0;
        r_sugar[i]  <= 1'b0;
      end
    end else if (clear_row) begin
      for (int i = 0; i < PIXELS_X; i++) begin
        r_signal[i] <= '0;
        r_sugar[i]  <= 1'b0;
      end
    end else begin
      if (w_sweeping) r_signal[r_ptr] <= w_ptr_decayed;
      if (w_wr_hit) begin
        r_signal[w_wr_idx] <= w_wr_new_sig;
        r_sugar[w_wr_idx]  <= w_wr_new_sug;
      end
    end
  end

  // Registered read ports; they sample the pre-edge contents, even on clear.
  always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      lookup_data <= '0;
      render_data <= '0;
    end else begin
      lookup_data <= w_lk_hit ? {r_signal[w_lk_idx], r_sugar[w_lk_idx]} : '0;
      render_data <= w_rd_hit ? {r_signal[w_rd_idx], r_sugar[w_rd_idx]} : '0;
    end
  end

  // Sugar population tracks only real 0->1 / 1->0 transitions of the written cell.
  always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
    if (!RESET_SIM_n) begin
      sugar_count <= '0;
    end else if (clear_row) begin
      sugar_count <= '0;
    end else if (w_wr_hit && (w_wr_new_sug != w_wr_old_sug)) begin
      if (w_wr_new_sug) sugar_count <= sugar_count + CNT_bits'(1);
      else              sugar_count <= sugar_count - CNT_bits'(1);
    end
  end

endmodule

// File: tb/tb_env_row_decay.sv
// Bench for env_row_decay: directed scenarios with literal expectations, then
// randomized traffic, all compared each cycle against an array-based model.
module tb_env_row_decay;
  localparam int NP   = 8;
  localparam int XB   = 4;
  localparam int SB   = 4;
  localparam int STEP = 1;
  localparam int CB   = $clog2(NP + 1);
  localparam int SMAX = (1 << SB) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear_row = 1'b0;
  logic          write_en = 1'b0;
  logic [XB-1:0] write_X = '0;
  logic [1:0]    write_mode = '0;
  logic [SB-1:0] write_signal = '0;
  logic          write_sugar = 1'b0;
  logic          decay_tick = 1'b0;
  logic [XB-1:0] lookup_X = '0;
  logic [XB-1:0] render_X = '0;
  logic [SB:0]   lookup_data;
  logic [SB:0]   render_data;
  logic          sweep_busy;
  logic [CB-1:0] sugar_count;

  always #5 clk = ~clk;

  env_row_decay #(
    .PIXELS_X(NP), .X_bits(XB), .SIGNAL_bits(SB), .DECAY_STEP(STEP), .CNT_bits(CB)
  ) dut (
    .newLocClock (clk),
    .RESET_SIM_n (rst_n),
    .clear_row   (clear_row),
    .write_en    (write_en),
    .write_X     (write_X),
    .write_mode  (write_mode),
    .write_signal(write_signal),
    .write_sugar (write_sugar),
    .decay_tick  (decay_tick),
    .lookup_X    (lookup_X),
    .lookup_data (lookup_data),
    .render_X    (render_X),
    .render_data (render_data),
    .sweep_busy  (sweep_busy),
    .sugar_count (sugar_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain arrays, sweep position (-1 when idle), pending flag.
  int m_sig [NP];
  int m_sug [NP];
  int m_pos = -1;
  bit m_pend = 1'b0;
  int e_lk = 0, e_rd = 0, e_busy = 0, e_cnt = 0;

  function automatic int cell_word(input int x);
    if (x >= NP) return 0;
    return m_sig[x] * 2 + m_sug[x];
  endfunction

  task automatic model_step();
    int ns [NP];
    int nu [NP];
    int s;
    e_lk = cell_word(int'(lookup_X));
    e_rd = cell_word(int'(render_X));
    if (clear_row) begin
      for (int i = 0; i < NP; i++) begin
        m_sig[i] = 0;
        m_sug[i] = 0;
      end
      m_pos  = -1;
      m_pend = 1'b0;
    end else begin
      ns = m_sig;
      nu = m_sug;
      if (m_pos >= 0) ns[m_pos] = (m_sig[m_pos] > STEP) ? m_sig[m_pos] - STEP : 0;
      if (write_en && int'(write_X) < NP) begin
        case (write_mode)
          2'd0: begin ns[write_X] = int'(write_signal); nu[write_X] = int'(write_sugar); end
          2'd1: begin s = ns[write_X] + int'(write_signal); ns[write_X] = (s > SMAX) ? SMAX : s; end
          2'd2: nu[write_X] = 1;
          default: nu[write_X] = 0;
        endcase
      end
      m_sig = ns;
      m_sug = nu;
      if (m_pos < 0) begin
        if (decay_tick) m_pos = 0;
      end else begin
        if (decay_tick) m_pend = 1'b1;
        if (m_pos == NP - 1) begin
          if (m_pend) begin m_pos = 0; m_pend = 1'b0; end
          else m_pos = -1;
        end else begin
          m_pos++;
        end
      end
    end
    e_busy = (m_pos >= 0) ? 1 : 0;
    e_cnt = 0;
    for (int i = 0; i < NP; i++) e_cnt += m_sug[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        m_sig[i] = 0;
        m_sug[i] = 0;
      end
      m_pos = -1; m_pend = 1'b0;
      e_lk = 0; e_rd = 0; e_busy = 0; e_cnt = 0;
    end else begin
      model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("lookup_data", int'(lookup_data), e_lk);
      chk("render_data", int'(render_data), e_rd);
      chk("sweep_busy", int'(sweep_busy), e_busy);
      chk("sugar_count", int'(sugar_count), e_cnt);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    write_en = 1'b0; decay_tick = 1'b0; clear_row = 1'b0;
  endtask

  task automatic wr(input int x, input int mode, input int sig, input int sug);
    write_en = 1'b1;
    write_X = XB'(x);
    write_mode = 2'(mode);
    write_signal = SB'(sig);
    write_sugar = sug[0];
  endtask

  // Counts consecutive busy cycles from now; optional ticks at listed offsets.
  task automatic run_len(input int tick_a, input int tick_b, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!sweep_busy) break;
      n++;
      decay_tick = (k == tick_a || k == tick_b);
      step();
    end
    decay_tick = 1'b0;
  endtask

  int pat [4] = '{0, 1, 5, 15};
  int after1 [4] = '{0, 0, 4, 14};
  int after5 [4] = '{0, 0, 0, 10};
  int n;

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    chk("reset_busy", int'(sweep_busy), 0);
    chk("reset_count", int'(sugar_count), 0);
    for (int x = 0; x < NP; x++) begin
      lookup_X = XB'(x); render_X = XB'(NP - 1 - x);
      step();
      chk("reset_lookup", int'(lookup_data), 0);
      chk("reset_render", int'(render_data), 0);
    end

    // Overwrite then saturating add; read in the write cycle sees the old value.
    lookup_X = 4'd3;
    wr(3, 0, 9, 1); step();
    chk("pre_write_read", int'(lookup_data), 0);
    wr(3, 1, 10, 0); step();
    chk("pre_add_read", int'(lookup_data), 19);
    idle(); step();
    chk("sat_add", int'(lookup_data), 31);
    chk("count_after_set", int'(sugar_count), 1);

    // Preload and single sweep.
    for (int x = 0; x < NP; x++) begin wr(x, 0, pat[x % 4], 0); step(); end
    idle();
    decay_tick = 1'b1; step(); decay_tick = 1'b0;
    run_len(-1, -1, n);
    chk("sweep_len", n, NP);
    for (int x = 0; x < NP; x++) begin
      lookup_X = XB'(x); step();
      chk("decay_once", int'(lookup_data), after1[x % 4] * 2);
    end

    // Ticks mid-sweep collapse into one extra sweep; a final-cycle tick also counts.
    decay_tick = 1'b1; step();
    run_len(2, 3, n);
    chk("pending_len", n, 2 * NP);
    decay_tick = 1'b1; step();
    run_len(NP - 1, -1, n);
    chk("final_tick_len", n, 2 * NP);
    for (int x = 0; x < NP; x++) begin
      lookup_X = XB'(x); step();
      chk("decay_five", int'(lookup_data), after5[x % 4] * 2);
    end

    // Writes colliding with the sweep pointer.
    wr(2, 0, 5, 0); step();
    wr(5, 2, 0, 0); step(); idle(); step();
    chk("count_col5", int'(sugar_count), 1);
    decay_tick = 1'b1; step(); idle(); step(); step();
    wr(2, 1, 3, 0); step(); idle();
    run_len(-1, -1, n);
    lookup_X = 4'd2; step();
    chk("decay_then_add", int'(lookup_data), 14);
    decay_tick = 1'b1; step(); idle(); step(); step();
    wr(2, 0, 5, 0); step();
    wr(9, 2, 0, 0); step(); idle();
    run_len(-1, -1, n);
    lookup_X = 4'd2; step();
    chk("overwrite_wins", int'(lookup_data), 10);
    chk("oob_write_count", int'(sugar_count), 1);

    // clear_row mid-sweep with a colliding write and tick.
    decay_tick = 1'b1; step(); idle(); step();
    wr(1, 0, 3, 1); decay_tick = 1'b1; clear_row = 1'b1; lookup_X = 4'd2;
    step(); idle();
    chk("clear_busy", int'(sweep_busy), 0);
    chk("clear_count", int'(sugar_count), 0);
    chk("clear_pre_read", int'(lookup_data), 10);
    lookup_X = 4'd1; step();
    chk("clear_cell1", int'(lookup_data), 0);
    repeat (3) step();
    chk("clear_no_pending", int'(sweep_busy), 0);

    // Asynchronous reset in the middle of a cycle.
    wr(4, 0, 9, 1); step(); idle();
    lookup_X = 4'd4; render_X = 4'd4; step();
    chk("pre_reset_lookup", int'(lookup_data), 19);
    decay_tick = 1'b1; step(); decay_tick = 1'b0;
    chk("pre_reset_busy", int'(sweep_busy), 1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("async_lookup", int'(lookup_data), 0);
    chk("async_render", int'(render_data), 0);
    chk("async_busy", int'(sweep_busy), 0);
    chk("async_count", int'(sugar_count), 0);
    step(); rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      write_en     = ($urandom_range(1, 0) == 1);
      write_X      = XB'($urandom_range(15, 0));
      write_mode   = 2'($urandom_range(3, 0));
      write_signal = SB'($urandom_range(15, 0));
      write_sugar  = $urandom_range(1, 0) == 1;
      decay_tick   = ($urandom_range(15, 0) == 0);
      clear_row    = ($urandom_range(127, 0) == 0);
      lookup_X     = XB'($urandom_range(15, 0));
      render_X     = XB'($urandom_range(15, 0));
      step();
    end
    idle(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/env_row_decay.md
Name: env_row_decay

Overview:
Parametrised next-generation environment row: a register file of PIXELS_X cells, each holding {signal, sugar}, with registered lookup and render read ports. Adds pheromone evaporation, which is a sequential sweep subtracting DECAY_STEP from every cell's signal. Adds write modes: overwrite, saturating deposit, sugar set and sugar take. Keeps a live count of sugar cells in the row. Instantiated once per row in the environment; the environment module drives decay_tick for all rows together.

Parameters:
PIXELS_X, 640, cells in the row.
X_bits, 10, column index width; must satisfy 2^X_bits >= PIXELS_X.
SIGNAL_bits, 4, pheromone signal width.
DECAY_STEP, 1, amount subtracted per sweep; range 0..2^SIGNAL_bits-1.
CNT_bits, $clog2(PIXELS_X+1), width of sugar_count.

Ports:
newLocClock  in  1  clock; all state updates on the rising edge.
RESET_SIM_n  in  1  asynchronous, active-low reset.
clear_row  in  1  synchronous clear of the whole row.
write_en  in  1  write strobe.
write_X  in  X_bits  target column.
write_mode  in  2  00 overwrite, 01 saturating add to signal, 10 set sugar, 11 take sugar.
write_signal  in  SIGNAL_bits  signal operand.
write_sugar  in  1  sugar value, used in mode 00 only.
decay_tick  in  1  request one evaporation sweep.
lookup_X  in  X_bits  lookup column.
lookup_data  out  SIGNAL_bits+1  {signal, sugar}; sugar is bit 0.
render_X  in  X_bits  render column.
render_data  out  SIGNAL_bits+1  {signal, sugar}.
sweep_busy  out  1  high while a sweep is in progress.
sugar_count  out  CNT_bits  number of cells with sugar=1.

Behaviour:
- Reset (RESET_SIM_n=0, asynchronous):
  - All cells become 0.
  - lookup_data, render_data, sweep_busy and sugar_count become 0.
  - FSM goes to IDLE; ptr=0; pending=0.
- Reads:
  - lookup_data and render_data are registered, 1-cycle latency: data_out(t+1) = cell[X(t)] as stored before the edge at t.
  - A read of a cell written in the same cycle returns the old value.
  - X >= PIXELS_X returns 0.
- Writes (write_en=1, write_X < PIXELS_X); one write per cycle:
  - 00: cell = {write_signal, write_sugar}.
  - 01: signal = min(signal + write_signal, 2^SIGNAL_bits-1); sugar unchanged.
  - 10: sugar = 1; signal unchanged.
  - 11: sugar = 0; signal unchanged.
  - write_X >= PIXELS_X: the write is ignored; no state change.
- Sweep FSM, states IDLE and SWEEP:
  - IDLE: decay_tick=1 -> SWEEP with ptr=0.
  - SWEEP: each cycle, cell[ptr].signal = max(signal - DECAY_STEP, 0) and ptr increments.
  - After processing ptr=PIXELS_X-1: if pending=1, clear pending and go to SWEEP with ptr=0 on the next edge; otherwise go to IDLE.
  - A sweep lasts exactly PIXELS_X cycles.
  - sweep_busy = (state==SWEEP), registered.
- decay_tick during SWEEP sets pending; repeated ticks collapse into one. decay_tick on the final sweep cycle also sets pending.
- Write and sweep on the same cell in the same cycle:
  - Mode 00: the write wins; no decay is applied.
  - Mode 01: decay first, clamp at 0, then saturating add.
  - Modes 10/11: decay is applied to signal and the sugar update is applied.
- clear_row has highest priority:
  - All cells = 0; sugar_count = 0.
  - Any sweep is aborted to IDLE; pending = 0.
  - The same-cycle write and decay_tick are ignored.
  - Reads issued that cycle return pre-clear values.
- sugar_count:
  - Updated on the same edge as the cell; +1 on a 0->1 sugar transition, -1 on a 1->0 transition.
  - Redundant set/take operations leave it unchanged.
  - Never wraps, since it is bounded by PIXELS_X.
- DECAY_STEP=0: sweeps still run and assert sweep_busy, but leave cells unchanged.

Test Plan:
1. Common parameters for all scenarios: PIXELS_X=8, SIGNAL_bits=4, DECAY_STEP=1.
2. Reset, then read all columns -> lookup_data=0 and render_data=0 everywhere; sweep_busy=0; sugar_count=0.
3. Overwrite col 3 with {9,1}, then mode 01 add 10 to col 3 -> lookup(3)={15,1} (saturated); sugar_count=1. Read col 3 in the write cycle -> returns the pre-write value.
4. Preload cols 0..7 with signal 0,1,5,15. Pulse decay_tick -> sweep_busy high for 8 cycles; signals become 0,0,4,14. Ticks during the sweep -> exactly one back-to-back second sweep.
5. During a sweep, at ptr=2, write col 2: mode 01 add 3 to signal 5 -> 7; mode 00 {5,0} -> {5,0}. Mode 10 on col 9 -> ignored; sugar_count unchanged.
6. Mid-sweep, assert clear_row with a write to col 1 -> all cells 0, sweep_busy=0 next cycle, pending cleared, sugar_count=0. Then assert RESET_SIM_n=0 mid-cycle -> outputs 0 immediately, without waiting for a clock edge.
